dsp_chain_acc_drain: RTL and testbench
======================================

DSP_CHAIN_ACC_DRAIN -- requirements
Module: dsp_chain_acc_drain

Interface
REQ-001 SHALL have parameter: CHAIN_LATENCY, 4, cycles from operand issue into the 4-stage int_sop_2 chain until the matching chain result is valid.
REQ-002 SHALL have parameter: CNT_W, 16, width of the per-sum term counter.
REQ-003 SHALL have port: clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: issue_valid  input  1  upstream presents an operand set to the chain this cycle.
REQ-006 SHALL have port: issue_last  input  1  qualifies issue_valid; the set is the final term of a sum.
REQ-007 SHALL have port: issue_ready  output  1  block accepts the issue; issue_fire = issue_valid & issue_ready.
REQ-008 SHALL have port: chain_result  input  37  signed result from the last chain stage.
REQ-009 SHALL have port: out_valid  output  1  completed sum available.
REQ-010 SHALL have port: out_ready  input  1  downstream accepts; pop = out_valid & out_ready.
REQ-011 SHALL have port: out_data  output  48  signed completed sum.
REQ-012 SHALL have port: out_count  output  CNT_W  number of terms in out_data, saturating at all-ones.
REQ-013 SHALL have port: out_overflow  output  1  signed 48-bit overflow occurred during this sum.

Function
REQ-014 SHALL carry {valid,last} of each issue_fire through a CHAIN_LATENCY-stage delay line so it aligns with chain_result (aligned valid = av, aligned last = al).
REQ-015 SHALL ignore chain_result whenever av = 0.
REQ-016 SHALL use a two-state FSM: IDLE (no partial sum) and ACCUM (partial sum held).
REQ-017 On av in IDLE: acc <= sext48(chain_result), cnt <= 1, ovf <= 0; goes to ACCUM unless al.
REQ-018 On av in ACCUM: acc <= acc + sext48(chain_result), cnt <= cnt+1 (saturating), ovf <= ovf | signed-add overflow; stays ACCUM unless al.
REQ-019 On av & al: the final {acc, cnt, ovf} including this term SHALL be pushed to a 2-entry output FIFO and the FSM SHALL return to IDLE.
REQ-020 out_valid SHALL be FIFO non-empty; out_data/out_count/out_overflow SHALL be the head entry, held stable while out_valid & !out_ready.
REQ-021 Latency: last issued at cycle t SHALL give out_valid at t+CHAIN_LATENCY+1 when the FIFO is empty.
REQ-022 A reservation counter SHALL count FIFO occupancy plus in-flight lasts: +1 on issue_fire & issue_last, -1 on pop, net 0 when both occur together.
REQ-023 issue_ready SHALL be (reserved < 2); push to a full FIFO SHALL therefore never occur.
REQ-024 Simultaneous push and pop SHALL keep occupancy unchanged and preserve FIFO order.

Reset
REQ-025 On reset: delay line cleared, FSM = IDLE, acc = 0, cnt = 0, ovf = 0, FIFO empty, reserved = 0.
REQ-026 After reset: out_valid = 0, out_data = 0, out_count = 0, out_overflow = 0, issue_ready = 1.
REQ-027 Reset mid-sum SHALL discard the partial sum and all in-flight tags; chain results arriving after reset SHALL be ignored.

Structure
REQ-028 Package dsp_chain_pkg SHALL hold CHAIN_W = 37, ACC_W = 48, OUT_FIFO_DEPTH = 2 and the FSM state typedef.
REQ-029 The output FIFO SHALL be sub-module dsp_chain_acc_fifo2; delay line, FSM, accumulator and reservation counter SHALL stay in the top module.

Verification (CHAIN_LATENCY = 4, out_ready = 1 unless stated)
REQ-030 Single term: last issued at t, chain_result = 100 at t+4 -> out_valid at t+5, out_data = 100, out_count = 1, out_overflow = 0.
REQ-031 Three terms 5, -3, 10 (last on third) -> out_data = 12, out_count = 3.
REQ-032 out_ready = 0 with three single-term sums issued back-to-back -> issue_ready = 0 after the second last; after one pop, issue_ready = 1 and the third completes; order is preserved.
REQ-033 2049 terms of 2^36-1 -> out_overflow = 1, out_count = 2049; the next sum starts with out_overflow = 0.
REQ-034 Two non-last terms, then reset, then a single last term of 7 -> out_data = 7, out_count = 1.
REQ-035 Push and pop in the same cycle at occupancy 1 -> occupancy stays 1, reserved stays consistent, and no entry is lost or duplicated.

Source files
------------

// File: rtl/dsp_chain_pkg.sv
// Shared widths, FIFO depth and accumulator FSM state for the int_sop_2 chain
// accumulate-and-drain block.
package dsp_chain_pkg;

  localparam int CHAIN_W        = 37;
  localparam int ACC_W          = 48;
  localparam int OUT_FIFO_DEPTH = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_t;

  function automatic logic [ACC_W-1:0] sext_chain(input logic [CHAIN_W-1:0] v);
    return {{(ACC_W - CHAIN_W){v[CHAIN_W-1]}}, v};
  endfunction

endpackage

// File: rtl/dsp_chain_acc_fifo2.sv
// Two-entry output FIFO holding completed {sum, count, overflow} records;
// head is registered storage, so it stays stable until popped.
module dsp_chain_acc_fifo2
  import dsp_chain_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty
);

  logic [W-1:0] mem [OUT_FIFO_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((count != 2'(OUT_FIFO_DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the two entries are reset so an empty FIFO presents an all-zero head.
      for (int i = 0; i < OUT_FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dsp_chain_acc_drain.sv
// Accumulates int_sop_2 chain results into 48-bit sums delimited by issue_last,
// and queues completed sums with term count and overflow flag.
module dsp_chain_acc_drain
  import dsp_chain_pkg::*;
#(
  parameter int CHAIN_LATENCY = 4,
  parameter int CNT_W         = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               issue_valid,
  input  logic               issue_last,
  output logic               issue_ready,
  input  logic [CHAIN_W-1:0] chain_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_data,
  output logic [CNT_W-1:0]   out_count,
  output logic               out_overflow
);

  localparam int REC_W = ACC_W + CNT_W + 1;

  logic [CHAIN_LATENCY-1:0] tag_vld;
  logic [CHAIN_LATENCY-1:0] tag_lst;
  logic                     issue_fire;
  logic                     av;
  logic                     al;
  logic                     pop;
  logic                     push;
  logic                     empty;

  acc_state_t               state_q, state_d;
  logic [ACC_W-1:0]         acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     ovf_q, ovf_d;
  logic [ACC_W-1:0]         term;
  logic [ACC_W-1:0]         sum;
  logic                     add_ovf;
  logic [1:0]               reserved_q;
  logic [REC_W-1:0]         head;

  assign issue_ready = (reserved_q < 2'(OUT_FIFO_DEPTH));
  assign issue_fire  = issue_valid & issue_ready;
  assign av          = tag_vld[CHAIN_LATENCY-1];
  assign al          = tag_lst[CHAIN_LATENCY-1];
  assign out_valid   = !empty;
  assign pop         = out_valid & out_ready;

  // Tags ride alongside the operands so they line up with chain_result.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_vld <= '0;
      tag_lst <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the old value of its neighbour.
      tag_vld[0] <= issue_fire;
      tag_lst[0] <= issue_fire & issue_last;
      for (int i = 1; i < CHAIN_LATENCY; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_lst[i] <= tag_lst[i-1];
      end
    end
  end

  assign term    = sext_chain(chain_result);
  assign sum     = acc_q + term;
  assign add_ovf = (acc_q[ACC_W-1] == term[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path infers a latch.
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    push    = 1'b0;
    if (av) begin
      if (state_q == IDLE) begin
        acc_d = term;
        cnt_d = CNT_W'(1);
        ovf_d = 1'b0;
      end else begin
        acc_d = sum;
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        ovf_d = ovf_q | add_ovf;
      end
      push    = al;
      state_d = al ? IDLE : ACCUM;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Occupancy plus lasts still in the chain; gating issue on it keeps the FIFO from overfilling.
  always_ff @(posedge clk) begin
    if (reset) begin
      reserved_q <= 2'd0;
    end else begin
      case ({issue_fire & issue_last, pop})
        2'b10:   reserved_q <= reserved_q + 2'd1;
        2'b01:   reserved_q <= reserved_q - 2'd1;
        default: reserved_q <= reserved_q;
      endcase
    end
  end

  dsp_chain_acc_fifo2 #(
    .W(REC_W)
  ) u_out_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({acc_d, cnt_d, ovf_d}),
    .pop       (pop),
    .head      (head),
    .empty     (empty)
  );

  assign {out_data, out_count, out_overflow} = head;

endmodule

// File: tb/tb_dsp_chain_acc_drain.sv
// Scoreboard bench: a behavioural chain model feeds chain_result, a reference
// accumulator queues expected sums, and a monitor compares them on every pop.
module tb_dsp_chain_acc_drain;

  localparam int CL    = 4;
  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_last = 1'b0;
  logic        issue_ready;
  logic [36:0] chain_result;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [47:0] out_data;
  logic [15:0] out_count;
  logic        out_overflow;

  logic [36:0] issue_term = '0;
  logic [36:0] pipe [CL];

  typedef struct packed {
    logic [47:0] data;
    logic [15:0] cnt;
    logic        ovf;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;

  logic [47:0] m_acc = '0;
  logic [15:0] m_cnt = '0;
  logic        m_ovf = 1'b0;
  bit          m_active = 1'b0;

  dsp_chain_acc_drain #(
    .CHAIN_LATENCY(CL),
    .CNT_W        (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_last   (issue_last),
    .issue_ready  (issue_ready),
    .chain_result (chain_result),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_count    (out_count),
    .out_overflow (out_overflow)
  );

  always #5 clk = ~clk;

  // Chain model: operand accepted at an edge appears on chain_result CL cycles later; junk otherwise.
  always @(posedge clk) begin
    pipe[0] <= (issue_valid && issue_ready) ? issue_term : 37'($urandom());
    for (int i = 1; i < CL; i++) pipe[i] <= pipe[i-1];
  end
  assign chain_result = pipe[CL-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_term(input logic signed [36:0] t, input logic l);
    longint a, b, wide;
    longint maxv, minv;
    maxv = (longint'(1) <<< 47) - 1;
    minv = -(longint'(1) <<< 47);
    b = t;
    if (!m_active) begin
      m_acc = b[47:0];
      m_cnt = 16'd1;
      m_ovf = 1'b0;
    end else begin
      a = $signed(m_acc);
      wide = a + b;
      if (wide > maxv || wide < minv) m_ovf = 1'b1;
      m_acc = wide[47:0];
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    if (l) begin
      sb.push_back({m_acc, m_cnt, m_ovf});
      m_active = 1'b0;
    end else begin
      m_active = 1'b1;
    end
  endtask

  // Presents one operand; returns #1 after the edge that accepted it.
  task automatic send(input logic signed [36:0] t, input logic l);
    int w = 0;
    issue_valid = 1'b1;
    issue_term  = t;
    issue_last  = l;
    while (!issue_ready && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (!issue_ready) check("issue_timeout", issue_ready, 1);
    @(posedge clk); #1;
    model_term(t, l);
    issue_valid = 1'b0;
    issue_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int w = 0;
    while (sb.size() != 0 && w < 500) begin
      @(posedge clk); #1;
      w++;
    end
    check("drain_left", sb.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    check("no_extra_out", out_valid, 0);
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", out_valid, 0);
      end else begin
        mon_e = sb.pop_front();
        check("out_data", out_data, mon_e.data);
        check("out_count", out_count, mon_e.cnt);
        check("out_overflow", out_overflow, mon_e.ovf);
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_count", out_count, 0);
    check("rst_out_overflow", out_overflow, 0);
    check("rst_issue_ready", issue_ready, 1);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single term: latency from the accepting edge to out_valid.
    send(100, 1'b1);
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, CL + 1);
    wait_drain();

    // Multi-term sum.
    send(5, 1'b0);
    send(-3, 1'b0);
    send(10, 1'b1);
    wait_drain();

    // Backpressure: two lasts fill the reservation, one pop frees a slot.
    out_ready = 1'b0;
    send(1, 1'b1);
    send(2, 1'b1);
    check("ready_full", issue_ready, 0);
    repeat (8) @(posedge clk);
    #1;
    check("ready_hold", issue_ready, 0);
    check("valid_held", out_valid, 1);
    check("head_held", out_data, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("ready_after_pop", issue_ready, 1);
    send(3, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    check("head_second", out_data, 2);
    out_ready = 1'b1;
    wait_drain();

    // Push and pop on the same edge at occupancy 1.
    out_ready = 1'b0;
    send(11, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    send(22, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("occ_valid", out_valid, 1);
    check("occ_head", out_data, 22);
    check("occ_ready", issue_ready, 1);
    send(33, 1'b1);
    check("occ_ready_full", issue_ready, 0);
    out_ready = 1'b1;
    wait_drain();

    // Overflow over 2049 max-positive terms, then a clean sum.
    for (int i = 0; i < 2049; i++) send(37'((64'd1 << 36) - 1), i == 2048);
    send(5, 1'b1);
    wait_drain();

    // Reset mid-sum discards the partial and in-flight tags.
    send(50, 1'b0);
    send(60, 1'b0);
    reset = 1'b1;
    m_active = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid_rst_ready", issue_ready, 1);
    send(7, 1'b1);
    wait_drain();

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
